// File: rtl/t481_pattern_driver_if.sv
// Bundles the control, result and DUT-facing signals of the t481 pattern driver.
// Latency: none, wiring only.
// Backpressure: none; start/done is a request/pulse pair and the driver owns pacing.
// master: controller plus t481 side (drives start/abort/mode/num_vec, and resp_in from t481).
// slave:  the pattern driver itself.
interface t481_pattern_driver_if;
  logic        start;
  logic        abort;
  logic        mode;
  logic [16:0] num_vec;
  logic [15:0] vec_out;
  logic        resp_in;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [16:0] ones_count;

  modport master (
    output start, abort, mode, num_vec, resp_in,
    input  vec_out, busy, done, signature, ones_count
  );

  modport slave (
    input  start, abort, mode, num_vec, resp_in,
    output vec_out, busy, done, signature, ones_count
  );
endinterface

// File: rtl/t481_pattern_driver.sv
// Drives exhaustive or LFSR vectors into t481 and compacts v160 into a MISR signature and ones count.
// Latency: 2 cycles per vector (APPLY settle + SAMPLE); done pulses 2N+1 cycles after the start cycle.
// Backpressure: none; start is ignored outside IDLE, abort returns to IDLE from APPLY/SAMPLE.
// Ports: clk, rst_n (async active-low); bus.slave carries start/abort/mode/num_vec in,
//        vec_out/resp_in to and from t481, busy/done/signature/ones_count out.
module t481_pattern_driver #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [15:0] LFSR_POLY = 16'hB400,
  parameter logic [15:0] MISR_POLY = 16'h1021
) (
  input logic                   clk,
  input logic                   rst_n,
  t481_pattern_driver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [16:0] EXH_COUNT = 17'h10000;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] vec_q;
  logic        mode_q;
  logic [16:0] num_vec_q;
  logic [16:0] vec_cnt;
  logic [15:0] sig_q;
  logic [16:0] ones_q;

  logic        busy_c;
  logic        done_c;
  logic [16:0] cnt_inc;
  logic [16:0] target;
  logic        last_vec;
  logic [15:0] lfsr_nxt;
  logic [15:0] vec_nxt;
  logic        misr_fb;
  logic [15:0] sig_nxt;

  // Datapath next values, only consumed in SAMPLE.
  always_comb begin
    cnt_inc  = vec_cnt + 17'd1;
    target   = mode_q ? num_vec_q : EXH_COUNT;
    last_vec = (cnt_inc == target);
    lfsr_nxt = vec_q[0] ? ((vec_q >> 1) ^ LFSR_POLY) : (vec_q >> 1);
    vec_nxt  = mode_q ? lfsr_nxt : (vec_q + 16'd1);
    misr_fb  = sig_q[15] ^ bus.resp_in;
    sig_nxt  = {sig_q[14:0], 1'b0} ^ ({16{misr_fb}} & MISR_POLY);
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          // A zero-length LFSR run completes without applying any vector.
          state_nxt = (bus.mode && (bus.num_vec == 17'd0)) ? DONE : APPLY;
        end
      end
      APPLY: begin
        busy_c    = 1'b1;
        state_nxt = bus.abort ? IDLE : SAMPLE;
      end
      SAMPLE: begin
        busy_c = 1'b1;
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (last_vec) begin
          state_nxt = DONE;
        end else begin
          state_nxt = APPLY;
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // vec_q doubles as the exhaustive counter and the LFSR register, so the
  // applied vector and the generator state can never diverge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= 16'h0000;
      mode_q    <= 1'b0;
      num_vec_q <= 17'd0;
      vec_cnt   <= 17'd0;
      sig_q     <= 16'h0000;
      ones_q    <= 17'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q    <= bus.mode;
            num_vec_q <= bus.num_vec;
            vec_cnt   <= 17'd0;
            sig_q     <= 16'h0000;
            ones_q    <= 17'd0;
            vec_q     <= bus.mode ? SEED_EFF : 16'h0000;
          end
        end
        SAMPLE: begin
          // abort wins over the capture: the partial results stay as they were.
          if (!bus.abort) begin
            sig_q   <= sig_nxt;
            ones_q  <= ones_q + {16'd0, bus.resp_in};
            vec_cnt <= cnt_inc;
            // The final vector stays on vec_out after the run.
            if (!last_vec) begin
              vec_q <= vec_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vec_out    = vec_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.signature  = sig_q;
  assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_t481_pattern_driver.sv
// Scoreboard bench for t481_pattern_driver: stimulus pushes expected vectors and
// run results; a negedge monitor checks every applied vector and every done pulse.
module tb_t481_pattern_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   resp_sel = 0;   // 0: v160 tied 0, 1: tied 1, 2: t481 stand-in function

  int   n_total = 0;
  int   n_pass  = 0;

  typedef struct packed {
    logic [15:0] sig;
    logic [16:0] ones;
    int          done_cyc;
    int          busy_cyc;
  } res_t;

  logic [15:0] vec_q[$];
  res_t        res_q[$];

  t481_pattern_driver_if bus();

  t481_pattern_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the t481 combinational block.
  function automatic logic resp_fn(input logic [15:0] v, input int sel);
    case (sel)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (^(v & 16'h5A3C)) ^ (v[15] & v[0]);
    endcase
  endfunction

  assign bus.resp_in = resp_fn(bus.vec_out, resp_sel);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: pushes the n_app applied vectors, compacts the first n_smp responses.
  task automatic model(input logic m, input int n_app, input int n_smp,
                       output logic [15:0] sig, output logic [16:0] ones);
    logic [15:0] v;
    logic        r;
    logic        fb;
    v    = m ? 16'hACE1 : 16'h0000;
    sig  = 16'h0000;
    ones = 17'd0;
    for (int i = 0; i < n_app; i++) begin
      vec_q.push_back(v);
      if (i < n_smp) begin
        r    = resp_fn(v, resp_sel);
        fb   = sig[15] ^ r;
        sig  = {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        ones = ones + {16'd0, r};
      end
      if (m) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      else   v = v + 16'd1;
    end
  endtask

  task automatic launch(input logic m, input logic [16:0] n, input logic [15:0] esig,
                        input logic [16:0] eones, input logic expect_done, output int s);
    res_t e;
    int   nv;
    @(negedge clk);
    bus.mode    = m;
    bus.num_vec = n;
    bus.start   = 1'b1;
    s           = cyc;
    nv          = m ? int'(n) : 65536;
    if (expect_done) begin
      e.sig      = esig;
      e.ones     = eones;
      e.done_cyc = s + 2 * nv + 1;
      e.busy_cyc = 2 * nv;
      res_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    repeat (2 * n + 3) @(negedge clk);
    check("run_completed", res_q.size(), 0);
  endtask

  // Monitor.
  initial begin
    int   busy_cyc;
    bit   phase;
    res_t e;
    busy_cyc = 0;
    phase    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cyc = 0;
        phase    = 1'b0;
      end else if (bus.done) begin
        if (res_q.size() == 0) begin
          n_total++;
          $display("FAIL done_extra: done pulse at cycle %0d with no run pending", cyc);
        end else begin
          e = res_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("busy_cycles", busy_cyc, e.busy_cyc);
          check("busy_in_done", bus.busy, 0);
          check("signature", bus.signature, e.sig);
          check("ones_count", bus.ones_count, e.ones);
        end
        busy_cyc = 0;
        phase    = 1'b0;
      end else if (bus.busy) begin
        if (!phase) begin
          if (vec_q.size() == 0) begin
            n_total++;
            $display("FAIL vec_extra: vec_out=%0h applied with no vector expected", bus.vec_out);
          end else begin
            check("vec_out", bus.vec_out, vec_q.pop_front());
          end
        end
        phase    = !phase;
        busy_cyc = busy_cyc + 1;
      end else begin
        busy_cyc = 0;
        phase    = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    int          s;
    logic [15:0] esig;
    logic [16:0] eones;
    res_t        e;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.mode    = 1'b0;
    bus.num_vec = 17'd0;
    repeat (3) @(negedge clk);
    check("rst_vec_out", bus.vec_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_signature", bus.signature, 0);
    check("rst_ones_count", bus.ones_count, 0);
    rst_n = 1'b1;

    // LFSR, one vector, v160 = 1.
    resp_sel = 1;
    vec_q.push_back(16'hACE1);
    launch(1'b1, 17'd1, 16'h1021, 17'd1, 1'b1, s);
    wait_done(1);

    // LFSR, two vectors; start held through the run and its DONE cycle, and
    // mode/num_vec changed after acceptance -- none of it may matter.
    vec_q.push_back(16'hACE1);
    vec_q.push_back(16'hE270);
    @(negedge clk);
    bus.mode    = 1'b1;
    bus.num_vec = 17'd2;
    bus.start   = 1'b1;
    s           = cyc;
    e.sig       = 16'h3063;
    e.ones      = 17'd2;
    e.done_cyc  = s + 5;
    e.busy_cyc  = 4;
    res_q.push_back(e);
    @(negedge clk);
    bus.mode    = 1'b0;
    bus.num_vec = 17'd7;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("held_start_run", res_q.size(), 0);

    // LFSR, zero vectors: immediate done, results cleared.
    launch(1'b1, 17'd0, 16'h0000, 17'd0, 1'b1, s);
    wait_done(0);

    // LFSR, 300 vectors through the t481 stand-in.
    resp_sel = 2;
    model(1'b1, 300, 300, esig, eones);
    launch(1'b1, 17'd300, esig, eones, 1'b1, s);
    wait_done(300);

    // Abort in the SAMPLE of the fifth vector: only vectors 0-3 counted.
    model(1'b1, 5, 4, esig, eones);
    launch(1'b1, 17'd10, 16'h0, 17'd0, 1'b0, s);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_s_busy", bus.busy, 0);
    check("abort_s_signature", bus.signature, esig);
    check("abort_s_ones_count", bus.ones_count, eones);

    // Exhaustive, abort in the APPLY of vector 130.
    model(1'b0, 131, 130, esig, eones);
    launch(1'b0, 17'd0, 16'h0, 17'd0, 1'b0, s);
    repeat (260) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_a_busy", bus.busy, 0);
    check("abort_a_vec_out", bus.vec_out, 16'd130);
    check("abort_a_signature", bus.signature, esig);
    check("abort_a_ones_count", bus.ones_count, eones);

    // Exhaustive, reset during vector 100.
    model(1'b0, 101, 100, esig, eones);
    launch(1'b0, 17'd0, 16'h0, 17'd0, 1'b0, s);
    repeat (200) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec_out", bus.vec_out, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_signature", bus.signature, 0);
    check("mid_rst_ones_count", bus.ones_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_signature", bus.signature, 0);

    check("vec_queue_empty", vec_q.size(), 0);
    check("res_queue_empty", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
